trng_arbiter: RTL and testbench

Shares one hardened TRNG (32-bit request/ready interface) between `NUM_REQ` internal consumers such as key generation, nonce generation and masking. Each consumer holds a request line. The arbiter grants consumers round-robin, drives the TRNG request, and returns the captured word to the granted consumer with a one-cycle valid pulse. A watchdog flags a TRNG that stops answering.

---
 rtl/trng_arb_pkg.sv | 17 +
 rtl/trng_rr_pick.sv | 36 +++
 rtl/trng_arbiter.sv | 156 +++++++++++++++
 tb/tb_trng_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_arb_pkg.sv
// rtl/trng_arb_pkg.sv - shared types, widths and helpers for trng_arbiter
package trng_arb_pkg;

    localparam int TRNG_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    // Index width for a set of n items; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trng_rr_pick.sv
// rtl/trng_rr_pick.sv - combinational round-robin picker: first set req bit at or after ptr
module trng_rr_pick
    import trng_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

    int               cand;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        cand      = 0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr never exceeds NUM_REQ-1, so one subtraction is enough to wrap
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            idx = IDX_W'(cand);
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

endmodule

// File: rtl/trng_arbiter.sv
// rtl/trng_arbiter.sv - round-robin sharing of one TRNG with timeout watchdog; TRNG_ARB_HEALTH_EN adds a repetition-count test
module trng_arbiter
    import trng_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  rnd_valid,
    output logic [TRNG_W-1:0]   rnd_data,
    output logic                trng_request,
    input  logic [TRNG_W-1:0]   trng_random_number,
    input  logic                trng_ready,
    output logic                busy,
    output logic                timeout_err,
    output logic                health_err,
    input  logic                err_clr
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam int               TMR_W    = idx_width(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [TMR_W-1:0] timer;

    logic start;
    logic capture;
    logic deliver;
    logic expire;
    logic reject;

    trng_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (req),
        .ptr       (ptr),
        .grant     (pick_idx),
        .any_valid (pick_any)
    );

`ifdef TRNG_ARB_HEALTH_EN
    logic [TRNG_W-1:0] prev_word;
    logic              prev_ok;

    // The first word after reset has nothing to be compared against.
    assign reject = prev_ok && (trng_random_number == prev_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_word  <= '0;
            prev_ok    <= 1'b0;
            health_err <= 1'b0;
        end else begin
            if (deliver) begin
                prev_word <= trng_random_number;
                prev_ok   <= 1'b1;
            end
            if (capture && reject) begin
                health_err <= 1'b1;
            end else if (err_clr) begin
                health_err <= 1'b0;
            end
        end
    end
`else
    assign reject     = 1'b0;
    assign health_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (deliver) begin
                    state_nxt = ST_DONE;
                end else if (expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        start   = (state == ST_IDLE) && pick_any;
        capture = (state == ST_WAIT) && trng_ready;
        deliver = capture && !reject;
        expire  = (state == ST_WAIT) && !trng_ready && (timer == TMR_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            grant_q      <= '0;
            timer        <= '0;
            trng_request <= 1'b0;
            rnd_valid    <= '0;
            rnd_data     <= '0;
        end else begin
            rnd_valid <= '0;
            if (start) begin
                grant_q      <= pick_idx;
                ptr          <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                trng_request <= 1'b1;
                timer        <= '0;
            end else if (capture && reject) begin
                // Repeated word: keep asking and give the TRNG a fresh window
                timer <= '0;
            end else if (deliver) begin
                rnd_data           <= trng_random_number;
                rnd_valid[grant_q] <= 1'b1;
                trng_request       <= 1'b0;
            end else if (expire) begin
                trng_request <= 1'b0;
            end else if (state == ST_WAIT) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (expire) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trng_arbiter.sv
// tb/tb_trng_arbiter.sv - self-checking bench for trng_arbiter with TRNG mock and round-robin reference model
module tb_trng_arbiter;

    localparam int NR = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] rnd_valid;
    logic [31:0]   rnd_data;
    logic          trng_request;
    logic [31:0]   trng_random_number = '0;
    logic          trng_ready = 1'b0;
    logic          busy;
    logic          timeout_err;
    logic          health_err;
    logic          err_clr = 1'b0;

    trng_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .rnd_valid          (rnd_valid),
        .rnd_data           (rnd_data),
        .trng_request       (trng_request),
        .trng_random_number (trng_random_number),
        .trng_ready         (trng_ready),
        .busy               (busy),
        .timeout_err        (timeout_err),
        .health_err         (health_err),
        .err_clr            (err_clr)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [NR-1:0] want = '0;
    int            mptr = 0;
    int            exp_q[$];
    logic          trq_prev = 1'b0;
    int            hi_cnt = 0;
    int            dly = 1;
    bit            dly_rand = 0;
    bit            mute = 0;
    int            word_ctr = 0;
    logic [31:0]   ovr_q[$];
    logic [31:0]   last_data = '0;
    int            n_deliv = 0;
    int            n_to = 0;
    bit            auto_req = 0;
    bit            track = 0;
    int            wait_c[NR];
    int            max_wait = 0;
    int            last_vidx = -1;
    int            cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first requester at or after p, wrapping.
    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        int c;
        for (int k = 0; k < NR; k++) begin
            c = (p + k) % NR;
            if (((r >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        ovr_q.delete();
        mptr      = 0;
        trq_prev  = 1'b0;
        hi_cnt    = 0;
        last_data = '0;
        word_ctr  = 0;
        for (int k = 0; k < NR; k++) wait_c[k] = 0;
    endtask

    task automatic step();
        logic [NR-1:0] req_e;
        logic          rdy_e;
        logic [31:0]   dat_e;
        logic          trq_e;
        logic [NR-1:0] onehot;
        int            g;
        req_e = req;
        rdy_e = trng_ready;
        dat_e = trng_random_number;
        trq_e = trq_prev;
        @(posedge clk);
        #1;
        cyc++;
        last_vidx = -1;
        if (trng_request) check("busy_when_req", busy, 1);
        if (trng_request && !trq_e) begin
            g = rr_pick(req_e, mptr);
            check("grant_has_req", g >= 0, 1);
            if (g >= 0) begin
                exp_q.push_back(g);
                mptr = (g + 1) % NR;
            end
        end
        if (trq_e && !trng_request && rnd_valid == '0) begin
            n_to++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (rnd_valid != '0) begin
            check("valid_onehot", $countones(rnd_valid), 1);
            check("valid_ready", rdy_e, 1);
            check("valid_granted", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                g = exp_q.pop_front();
                onehot = '0;
                onehot[g] = 1'b1;
                check("valid_idx", rnd_valid, onehot);
            end
            check("valid_data", rnd_data, dat_e);
            last_data = dat_e;
            for (int k = 0; k < NR; k++) begin
                if (rnd_valid[k]) begin
                    check("valid_pending", want[k], 1);
                    want[k]   = 1'b0;
                    wait_c[k] = 0;
                    last_vidx = k;
                end
            end
            n_deliv++;
        end else begin
            check("data_hold", rnd_data, last_data);
        end
        trq_prev = trng_request;

        // TRNG mock: registered response to a request held for dly cycles
        hi_cnt = trq_e ? hi_cnt + 1 : 0;
        if (dly_rand && hi_cnt == 0) dly = $urandom_range(1, 3);
        if (!mute && hi_cnt >= dly) begin
            trng_ready = 1'b1;
            if (ovr_q.size() > 0) begin
                trng_random_number = ovr_q.pop_front();
            end else begin
                word_ctr++;
                trng_random_number = word_ctr;
            end
        end else begin
            trng_ready = 1'b0;
            trng_random_number = $urandom;
        end

        for (int k = 0; k < NR; k++) begin
            if (auto_req && !want[k] && k != last_vidx && $urandom_range(0, 3) == 0) want[k] = 1'b1;
            if (track && want[k]) begin
                wait_c[k]++;
                if (wait_c[k] > max_wait) max_wait = wait_c[k];
            end
        end
        req = want;
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (rnd_valid == '0 && n < lim);
        check(tag, rnd_valid != '0, 1);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        want       = '0;
        req        = '0;
        err_clr    = 1'b0;
        trng_ready = 1'b0;
        mute       = 0;
        dly        = 1;
        dly_rand   = 0;
        auto_req   = 0;
        track      = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          to0;
        int          hi;
        bit          seen;
        int          prev_cyc;
        logic [31:0] prev_d;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", rnd_valid, 0);
        check("rst_data", rnd_data, 0);
        check("rst_treq", trng_request, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_herr", health_err, 0);

        // Single consumer, exact latency
        do_reset();
        n0 = n_deliv;
        want[0] = 1'b1;
        req = want;
        step();
        check("s_treq_e1", trng_request, 1);
        step();
        check("s_valid_e2", rnd_valid, 0);
        step();
        check("s_valid_e3", rnd_valid, 4'b0001);
        check("s_data_e3", rnd_data, 1);
        step();
        check("s_idle_e4", busy, 0);
        want[0] = 1'b1;
        req = want;
        wait_valid("s_second", 20);
        check("s_second_ge2", rnd_data >= 2, 1);
        repeat (8) step();
        check("s_no_double", n_deliv - n0, 2);

        // Contention from pointer 0
        do_reset();
        want = 4'b1111;
        req = want;
        prev_cyc = 0;
        prev_d = '0;
        for (int d = 0; d < NR; d++) begin
            wait_valid("c_deliver", 20);
            check("c_order", last_vidx, d);
            check("c_increasing", rnd_data > prev_d, 1);
            if (d > 0) check("c_spacing", cyc - prev_cyc, 4);
            prev_cyc = cyc;
            prev_d = rnd_data;
        end

        // Wrap-around: serve 2 so pointer sits at 3
        want = 4'b0100;
        req = want;
        wait_valid("w_pre", 20);
        check("w_pre_idx", last_vidx, 2);
        want = 4'b1001;
        req = want;
        wait_valid("w_first", 20);
        check("w_first_idx", last_vidx, 3);
        wait_valid("w_second", 20);
        check("w_second_idx", last_vidx, 0);

        // Timeout with a silent TRNG
        do_reset();
        to0 = n_to;
        mute = 1;
        want[1] = 1'b1;
        req = want;
        hi = 0;
        seen = 0;
        for (int s = 0; s < 40; s++) begin
            step();
            if (trng_request) begin
                hi++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        check("to_req_cycles", hi, TO);
        check("to_err", timeout_err, 1);
        check("to_no_valid", rnd_valid, 0);
        check("to_event", n_to - to0, 1);
        mute = 0;
        wait_valid("to_retry", 20);
        check("to_retry_idx", last_vidx, 1);
        check("to_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("to_err_clr", timeout_err, 0);

`ifdef TRNG_ARB_HEALTH_EN
        // Repetition test: second capture repeats the first delivered word
        do_reset();
        ovr_q.push_back(32'h5A5A5A5A);
        ovr_q.push_back(32'h5A5A5A5A);
        ovr_q.push_back(32'h5A5A5A5A);
        ovr_q.push_back(32'hC3C3_0001);
        want[0] = 1'b1;
        req = want;
        wait_valid("h_first", 20);
        check("h_first_data", rnd_data, 32'h5A5A5A5A);
        check("h_err_clear", health_err, 0);
        step();
        want[0] = 1'b1;
        req = want;
        hi = 0;
        for (int s = 0; s < 20; s++) begin
            step();
            if (trng_request) hi++;
            if (rnd_valid != '0) break;
        end
        check("h_second_data", rnd_data, 32'hC3C3_0001);
        check("h_req_held", hi, 3);
        check("h_err", health_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("h_err_clr", health_err, 0);
`endif

        // Asynchronous reset in the middle of WAIT
        mute = 1;
        want = 4'b0100;
        req = want;
        repeat (3) step();
        check("r_in_wait", trng_request, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("r_treq", trng_request, 0);
        check("r_busy", busy, 0);
        check("r_data", rnd_data, 0);
        check("r_valid", rnd_valid, 0);
        check("r_terr", timeout_err, 0);
        want = '0;
        req = '0;
        mute = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n0 = n_deliv;
        hi = 0;
        for (int s = 0; s < 8; s++) begin
            step();
            if (trng_request) hi++;
        end
        check("r_no_deliv", n_deliv - n0, 0);
        check("r_no_req", hi, 0);

        // Randomized traffic with variable TRNG latency
        do_reset();
        dly_rand = 1;
        auto_req = 1;
        track = 1;
        max_wait = 0;
        repeat (600) step();
        auto_req = 0;
        for (int s = 0; s < 100 && want != '0; s++) step();
        check("rand_drain", want, 0);
        check("rand_fair", max_wait <= 36, 1);
        check("rand_no_timeout", timeout_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
